// File: rtl/delay_align_pkg.sv
// Shared state encoding and default sizing for the delay_align lag finder.
package delay_pkg;
    typedef enum logic [1:0] {IDLE, SEARCH, LOCKED} state_e;

    localparam int DEF_W        = 4;
    localparam int DEF_MAX_LAG  = 7;
    localparam int DEF_LOCK_CNT = 4;
endpackage

// File: rtl/delay_align_if.sv
// Sample/control bundle between the reference + delayed streams and delay_align.
interface delay_align_if import delay_pkg::*; #(
    parameter int W  = DEF_W,
    parameter int LW = $clog2(DEF_MAX_LAG + 1)
);
    logic          start;
    logic [W-1:0]  ref_in;
    logic [W-1:0]  dly_in;
    logic          busy;
    logic          locked;
    logic [LW-1:0] lag;
    logic [W-1:0]  aligned;
    logic          err;
    logic          fail;

    modport master (output start, ref_in, dly_in,
                    input  busy, locked, lag, aligned, err, fail);
    modport slave  (input  start, ref_in, dly_in,
                    output busy, locked, lag, aligned, err, fail);
endinterface

// File: rtl/delay_align_tap_line.sv
// Reference history: taps[k] is din from k cycles ago, taps[0] is din itself.
// full rises once every stored tap holds a sample taken since reset.
module delay_tap_line #(
    parameter int  W     = 4,
    parameter int  DEPTH = 7,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic [W-1:0]          din,
    output logic [DEPTH:0][W-1:0] taps,
    output logic                  full
);
    logic [DEPTH:1][W-1:0] hist_q, hist_d;
    logic [CW-1:0]         fill_q, fill_d;

    always_comb begin
        hist_d    = hist_q;
        hist_d[1] = din;
        for (int k = 2; k <= DEPTH; k++) hist_d[k] = hist_q[k-1];
        fill_d = full ? fill_q : fill_q + CW'(1);
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

    assign full = (fill_q == CW'(DEPTH));
    assign taps = {hist_q, din};
endmodule

// File: rtl/delay_align.sv
// Finds the integer lag between a reference stream and its delayed copy, locks on it,
// then emits the realigned reference and a per-cycle mismatch flag.
module delay_align import delay_pkg::*; #(
    parameter int  W        = DEF_W,
    parameter int  MAX_LAG  = DEF_MAX_LAG,
    parameter int  LOCK_CNT = DEF_LOCK_CNT,
    localparam int LW       = $clog2(MAX_LAG + 1)
) (
    input logic          clk,
    input logic          clear,
    delay_align_if.slave bus
);
    localparam int TRIES = 2 * (MAX_LAG + 1);
    localparam int RW    = $clog2(LOCK_CNT + 1);
    localparam int TW    = $clog2(TRIES + 1);

    logic [MAX_LAG:0][W-1:0] taps;
    logic                    full;
    logic [W-1:0]            tap_cand, tap_lag;

    state_e        state_q, state_d;
    logic [LW-1:0] cand_q, cand_d, lag_q, lag_d;
    logic [RW-1:0] run_q, run_d, miss_q, miss_d;
    logic [TW-1:0] tries_q, tries_d;
    logic [W-1:0]  aligned_q, aligned_d;
    logic          err_q, err_d, fail_q, fail_d;

    delay_tap_line #(.W(W), .DEPTH(MAX_LAG)) u_taps (
        .clk  (clk),
        .clear(clear),
        .din  (bus.ref_in),
        .taps (taps),
        .full (full)
    );

    assign tap_cand = taps[cand_q];
    assign tap_lag  = taps[lag_q];

    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        run_d     = run_q;
        tries_d   = tries_q;
        miss_d    = miss_q;
        lag_d     = lag_q;
        aligned_d = aligned_q;
        err_d     = 1'b0;
        fail_d    = 1'b0;
        case (state_q)
            // comparisons stall until every tap holds real history
            SEARCH: if (full) begin
                if (tap_cand == bus.dly_in) begin
                    if (run_q == RW'(LOCK_CNT - 1)) begin
                        state_d = LOCKED;
                        lag_d   = cand_q;
                        miss_d  = '0;
                    end else begin
                        run_d = run_q + RW'(1);
                    end
                end else begin
                    run_d  = '0;
                    cand_d = (cand_q == LW'(MAX_LAG)) ? '0 : cand_q + LW'(1);
                    if (tries_q == TW'(TRIES - 1)) begin
                        fail_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        tries_d = tries_q + TW'(1);
                    end
                end
            end
            LOCKED: begin
                aligned_d = tap_lag;
                err_d     = (tap_lag != bus.dly_in);
                if (!err_d) begin
                    miss_d = '0;
                end else if (miss_q == RW'(LOCK_CNT - 1)) begin
                    state_d = SEARCH;
                    cand_d  = '0;
                    run_d   = '0;
                    tries_d = '0;
                end else begin
                    miss_d = miss_q + RW'(1);
                end
            end
            default: ;
        endcase
        // start overrides a same-cycle lock or give-up
        if (bus.start) begin
            state_d = SEARCH;
            cand_d  = '0;
            run_d   = '0;
            tries_d = '0;
            lag_d   = lag_q;
            fail_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q   <= IDLE;
            cand_q    <= '0;
            run_q     <= '0;
            tries_q   <= '0;
            miss_q    <= '0;
            lag_q     <= '0;
            aligned_q <= '0;
            err_q     <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            run_q     <= run_d;
            tries_q   <= tries_d;
            miss_q    <= miss_d;
            lag_q     <= lag_d;
            aligned_q <= aligned_d;
            err_q     <= err_d;
            fail_q    <= fail_d;
        end
    end

    assign bus.busy    = (state_q == SEARCH);
    assign bus.locked  = (state_q == LOCKED);
    assign bus.lag     = lag_q;
    assign bus.aligned = aligned_q;
    assign bus.err     = err_q;
    assign bus.fail    = fail_q;
endmodule

// File: tb/tb_delay_align.sv
// Bench for delay_align: directed lock/fail table, hand-built multi-cycle corners,
// and randomized lags checked against a cycle-indexed search model.
module tb_delay_align;
    localparam int W        = 4;
    localparam int MAX_LAG  = 7;
    localparam int LW       = 3;
    localparam int LOCK_CNT = 4;
    localparam int NC       = 100;

    logic clk   = 1'b0;
    logic clear = 1'b0;
    always #5 clk = ~clk;

    delay_align_if #(.W(W), .LW(LW)) bus ();

    delay_align #(.W(W), .MAX_LAG(MAX_LAG), .LOCK_CNT(LOCK_CNT)) dut (
        .clk  (clk),
        .clear(clear),
        .bus  (bus)
    );

    // per-cycle stimulus and observations; cycle t ends at the (t+1)-th edge after reset release
    int ref_a [NC];
    int dly_a [NC];
    int start_a [NC];
    int busy_o [NC];
    int locked_o [NC];
    int lag_o [NC];
    int aligned_o [NC];
    int err_o [NC];
    int fail_o [NC];

    int checks   = 0;
    int failures = 0;
    int pat [8]  = '{7, 10, 3, 12, 5, 14, 1, 0};

    typedef struct {
        int lag;
        int inv;
        int s;
        int exp_edges;
        int exp_lag;
        int exp_fail;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // reference sample seen k cycles before cycle t (history is zero before reset release)
    function automatic int tapv(input int t, input int k);
        return (t - k >= 0) ? ref_a[t - k] : 0;
    endfunction

    task automatic fill_pat(input int lag, input int inv);
        for (int t = 0; t < NC; t++) begin
            ref_a[t]   = (inv != 0) ? (t % 8) : pat[t % 8];
            start_a[t] = 0;
            dly_a[t]   = (inv != 0) ? (ref_a[t] ^ 15) : tapv(t, lag);
        end
    endtask

    task automatic set_delay(input int from, input int lag);
        for (int t = from; t < NC; t++) dly_a[t] = tapv(t, lag);
    endtask

    task automatic run_scn(input int n);
        bus.start  = 1'b0;
        bus.ref_in = '0;
        bus.dly_in = '0;
        clear      = 1'b0;
        repeat (2) @(posedge clk);
        #1 clear = 1'b1;
        for (int t = 0; t < n; t++) begin
            bus.start  = (start_a[t] != 0);
            bus.ref_in = W'(ref_a[t]);
            bus.dly_in = W'(dly_a[t]);
            @(negedge clk);
            busy_o[t]    = int'(bus.busy);
            locked_o[t]  = int'(bus.locked);
            lag_o[t]     = int'(bus.lag);
            aligned_o[t] = int'(bus.aligned);
            err_o[t]     = int'(bus.err);
            fail_o[t]    = int'(bus.fail);
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
    endtask

    // Search outcome for a start pulse in cycle s: the cycle in which locked (or fail)
    // is first observed, and the lag found.
    task automatic model_search(input int s, input int n, output int ev, output int evlag,
                                output int evfail);
        int cand  = 0;
        int run   = 0;
        int tries = 0;
        ev     = -1;
        evlag  = 0;
        evfail = 0;
        for (int t = s + 1; t < n; t++) begin
            if (t < MAX_LAG) continue;
            if (tapv(t, cand) == dly_a[t]) begin
                run++;
                if (run == LOCK_CNT) begin
                    ev    = t + 1;
                    evlag = cand;
                    return;
                end
            end else begin
                run  = 0;
                cand = (cand + 1) % (MAX_LAG + 1);
                tries++;
                if (tries == 2 * (MAX_LAG + 1)) begin
                    ev     = t + 1;
                    evfail = 1;
                    return;
                end
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [5];
        int   e, s, x, cnt, ev, evlag, evfail, lg, st;

        vt = '{'{3, 0, 10,  7, 3, 0},
               '{0, 0, 10,  4, 0, 0},
               '{7, 0, 10, 11, 7, 0},
               '{5, 0, 12,  9, 5, 0},
               '{0, 1, 10, 16, 0, 1}};

        // reset state while clear is held low
        bus.start = 1'b0; bus.ref_in = '0; bus.dly_in = '0;
        clear = 1'b0;
        #1;
        chk("reset_busy",    int'(bus.busy),    0);
        chk("reset_locked",  int'(bus.locked),  0);
        chk("reset_fail",    int'(bus.fail),    0);
        chk("reset_aligned", int'(bus.aligned), 0);

        foreach (vt[i]) begin
            fill_pat(vt[i].lag, vt[i].inv);
            s = vt[i].s;
            start_a[s] = 1;
            run_scn(60);
            e = s + 1 + vt[i].exp_edges;
            chk($sformatf("v%0d_out_of_reset_busy", i), busy_o[0], 0);
            chk($sformatf("v%0d_busy_after_start", i), busy_o[s + 1], 1);
            if (vt[i].exp_fail == 0) begin
                chk($sformatf("v%0d_locked_before", i), locked_o[e - 1], 0);
                chk($sformatf("v%0d_locked_edge", i), locked_o[e], 1);
                chk($sformatf("v%0d_lag", i), lag_o[e], vt[i].exp_lag);
                chk($sformatf("v%0d_busy_at_lock", i), busy_o[e], 0);
                for (int c = e + 1; c <= e + 4; c++) begin
                    chk($sformatf("v%0d_aligned_c%0d", i, c), aligned_o[c], dly_a[c - 1]);
                    chk($sformatf("v%0d_err_c%0d", i, c), err_o[c], 0);
                end
            end else begin
                chk($sformatf("v%0d_fail_before", i), fail_o[e - 1], 0);
                chk($sformatf("v%0d_fail_pulse", i), fail_o[e], 1);
                chk($sformatf("v%0d_fail_after", i), fail_o[e + 1], 0);
                chk($sformatf("v%0d_busy_last_try", i), busy_o[e - 1], 1);
                chk($sformatf("v%0d_busy_at_fail", i), busy_o[e], 0);
                cnt = 0;
                for (int c = 0; c < 60; c++) cnt += locked_o[c];
                chk($sformatf("v%0d_never_locked", i), cnt, 0);
            end
        end

        // loss of lock: delay path switches from 3 to 5 while locked
        fill_pat(3, 0);
        start_a[10] = 1;
        x = 24;
        set_delay(x, 5);
        run_scn(60);
        chk("lol_locked_pre", locked_o[x + 3], 1);
        chk("lol_err_pre", err_o[x], 0);
        cnt = 0;
        for (int c = x; c <= x + 10; c++) cnt += err_o[c];
        chk("lol_err_cycles", cnt, 4);
        chk("lol_err_4th", err_o[x + 4], 1);
        chk("lol_locked_drop", locked_o[x + 4], 0);
        chk("lol_busy_rise", busy_o[x + 4], 1);
        chk("lol_busy_pre", busy_o[x + 3], 0);
        chk("lol_relock_before", locked_o[x + 12], 0);
        chk("lol_relock", locked_o[x + 13], 1);
        chk("lol_relock_lag", lag_o[x + 13], 5);

        // start while locked, then start in the cycle of the final match
        fill_pat(3, 0);
        start_a[10] = 1;
        start_a[22] = 1;
        start_a[29] = 1;
        run_scn(50);
        chk("rs_first_lock", locked_o[18], 1);
        chk("rs_locked_at_start", locked_o[22], 1);
        chk("rs_locked_drop", locked_o[23], 0);
        chk("rs_busy_restart", busy_o[23], 1);
        chk("rs_lock_preempted", locked_o[30], 0);
        chk("rs_busy_preempted", busy_o[30], 1);
        chk("rs_before_final", locked_o[36], 0);
        chk("rs_final_lock", locked_o[37], 1);
        chk("rs_final_lag", lag_o[37], 3);

        // asynchronous reset mid-search
        fill_pat(3, 0);
        start_a[12] = 1;
        run_scn(14);
        chk("ms_busy_pre", int'(bus.busy), 1);
        #2 clear = 1'b0;
        #1;
        chk("ms_rst_busy",   int'(bus.busy),   0);
        chk("ms_rst_locked", int'(bus.locked), 0);
        chk("ms_rst_fail",   int'(bus.fail),   0);
        repeat (3) @(negedge clk);
        chk("ms_rst_no_fail", int'(bus.fail), 0);

        // asynchronous reset mid-lock
        fill_pat(3, 0);
        start_a[10] = 1;
        run_scn(25);
        chk("ml_locked_pre", int'(bus.locked), 1);
        chk("ml_lag_pre", int'(bus.lag), 3);
        #2 clear = 1'b0;
        #1;
        chk("ml_rst_locked",  int'(bus.locked),  0);
        chk("ml_rst_lag",     int'(bus.lag),     0);
        chk("ml_rst_aligned", int'(bus.aligned), 0);
        chk("ml_rst_err",     int'(bus.err),     0);
        chk("ml_rst_busy",    int'(bus.busy),    0);

        // randomized lags and data, start possibly before the history is full
        for (int it = 0; it < 12; it++) begin
            lg = int'($urandom_range(MAX_LAG, 0));
            st = int'($urandom_range(20, 0));
            for (int t = 0; t < NC; t++) begin
                ref_a[t]   = int'($urandom_range(15, 0));
                start_a[t] = 0;
                dly_a[t]   = tapv(t, lg);
            end
            start_a[st] = 1;
            run_scn(80);
            model_search(st, 80, ev, evlag, evfail);
            chk($sformatf("r%0d_busy_after_start", it), busy_o[st + 1], 1);
            if (ev < 0 || ev + 4 >= 80) begin
                failures++;
                $display("FAIL r%0d_model_window: event cycle %0d outside 0..75", it, ev);
            end else if (evfail != 0) begin
                chk($sformatf("r%0d_fail", it), fail_o[ev], 1);
            end else begin
                chk($sformatf("r%0d_locked_before", it), locked_o[ev - 1], 0);
                chk($sformatf("r%0d_locked", it), locked_o[ev], 1);
                chk($sformatf("r%0d_lag", it), lag_o[ev], evlag);
                for (int c = ev + 1; c <= ev + 3; c++) begin
                    chk($sformatf("r%0d_aligned_c%0d", it, c), aligned_o[c], tapv(c - 1, evlag));
                    chk($sformatf("r%0d_err_c%0d", it, c), err_o[c],
                        int'(dly_a[c - 1] != tapv(c - 1, evlag)));
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/delay_align.md
# delay_align

Receive-side companion to the `delay` block. It watches a reference 4-bit sample stream and the delayed copy that comes out of a delay path. On request it searches for the integer cycle lag between them (0..MAX_LAG), locks once the lag is confirmed, then keeps producing the reference realigned to that lag and flags every mismatch. It sits downstream of `delay` in the capstone datapath and removes the inserted latency before comparison and checking logic.

## Interface
- `W`, 4, sample width
- `MAX_LAG`, 7, largest lag searched; `LW = $clog2(MAX_LAG+1)`
- `LOCK_CNT`, 4, consecutive matches needed to lock; also consecutive mismatches that drop lock
- `clk`  in  1  single clock, rising edge
- `clear`  in  1  reset, asynchronous, active-low
- `start`  in  1  one-cycle pulse that begins or restarts the lag search
- `ref_in`  in  W  undelayed reference sample, one per cycle
- `dly_in`  in  W  delayed sample from the delay path, one per cycle
- `busy`  out  1  high while in SEARCH
- `locked`  out  1  high while in LOCKED
- `lag`  out  LW  detected lag; valid while `locked`
- `aligned`  out  W  registered `tap(lag)`
- `err`  out  1  registered mismatch flag while locked
- `fail`  out  1  one-cycle pulse when the search gives up

## Operation
- History: `tap(0) = ref_in`; `tap(k) = ref_in` from k cycles ago, for k = 1..MAX_LAG, held in a shift register.
- Fill counter counts edges after reset and saturates at MAX_LAG. No comparison counts until the history is full.
- States: IDLE, SEARCH, LOCKED.
- IDLE:
  - `start` moves to SEARCH with `cand = 0`, `run = 0`, `tries = 0`.
- SEARCH (when history is full), one candidate comparison per cycle:
  - If `tap(cand) == dly_in`: `run++`. When `run` reaches LOCK_CNT, latch `lag = cand` and go to LOCKED.
  - On mismatch: `run = 0`; `cand = (cand == MAX_LAG) ? 0 : cand + 1` (wrap); `tries++`.
  - When `tries` reaches 2*(MAX_LAG+1): pulse `fail` and go to IDLE.
- Ties, such as a constant stream: the search starts at 0, so the lowest matching lag wins.
- LOCKED:
  - Every cycle: `aligned <= tap(lag)` and `err <= (dly_in != tap(lag))`.
  - LOCK_CNT consecutive mismatches: go to SEARCH with `cand = 0`, `run = 0`, `tries = 0`. `locked` falls and `busy` rises together.
- `start` in any state restarts SEARCH from `cand = 0`. `start` wins over a lock or a fail in the same cycle.
- `start` before the history is full: enter SEARCH, but comparisons stall until the fill counter saturates.

## Timing
- Reset (`clear` low, asynchronous):
  - All outputs are 0: `busy`, `locked`, `lag`, `aligned`, `err`, `fail`.
  - History is 0, fill counter is 0, state is IDLE.
  - Reset mid-search or mid-lock aborts immediately. No `fail` pulse.
- All outputs are registered. No combinational path from any input to any output.
- `start` sampled at edge E0: `busy` is high after E0. The first comparison is in the cycle after E0.
- Lock latency with true lag L and non-repeating data: L mismatch cycles plus LOCK_CNT match cycles. `locked` and `lag` update at the edge ending the last match cycle.
- `aligned` and `err` are first valid one edge after `locked` rises. Each lags its inputs by exactly one cycle.
- `fail` is high for exactly one cycle, the cycle after the last counted try, together with `busy` falling.

## Structure
- Package `delay_pkg`:
  - state enum {IDLE, SEARCH, LOCKED}
  - default constants W = 4, MAX_LAG = 7, LOCK_CNT = 4
- Sub-module `delay_tap_line`: parameterised shift register of depth MAX_LAG. Exposes all taps and the fill-done flag.
- Top level: FSM, the `cand`/`run`/`tries` counters, and the tap mux.

## Test plan
- Lock at lag 3:
  - Stimulus: repeat `ref_in` 7,10,3,12,5,14,1,0; `dly_in` = `ref_in` delayed 3; `start` pulse after fill.
  - Response: `locked` rises at edge 7 after the start edge; `lag` = 3; `aligned == dly_in` delayed one cycle; `err` = 0.
- Lag 0:
  - Stimulus: `dly_in = ref_in`.
  - Response: `lag` = 0, locked 4 edges after start.
- Lag MAX_LAG:
  - Stimulus: delay 7.
  - Response: `cand` runs 0..7, `lag` = 7, `locked` at edge 11.
- Loss of lock:
  - Stimulus: while locked at lag 3, change the delay to 5.
  - Response: `err` high for 4 cycles; `locked` falls and `busy` rises; relock with `lag` = 5.
- No match:
  - Stimulus: `dly_in` = `~ref_in`.
  - Response: `fail` pulses after 16 mismatching cycles; IDLE; `locked` = 0.
- Reset and restart:
  - Stimulus: `clear` low mid-search; then `start` during LOCKED; then `start` in the same cycle as the final match.
  - Response: all outputs 0 at once under reset; each `start` restarts the search from `cand = 0`.
